// File: rtl/ifid_stage_buf.sv
// IF/ID pipeline stage: registers the fetched instruction and PC, splits it into decode
// fields, and buffers in-flight fetches in a small FIFO while decode is stalled.
module ifid_stage_buf #(
  parameter int          PC_W      = 16,
  parameter int          BUF_DEPTH = 2,
  parameter logic [15:0] NOP_INST  = 16'hF000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [15:0]     instruction,
  input  logic [PC_W-1:0] PC_in,
  input  logic            data_hazard,
  input  logic            PC_hazard,
  output logic            id_valid,
  output logic [3:0]      cntrl_input,
  output logic [3:0]      reg_rd,
  output logic [2:0]      branch_cond,
  output logic [3:0]      reg_rs,
  output logic [3:0]      reg_rt,
  output logic [3:0]      arith_imm,
  output logic [7:0]      load_save_imm,
  output logic [11:0]     call_target,
  output logic [PC_W-1:0] PC_out,
  output logic [2:0]      buf_count
);

  localparam int                PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int                SLOTS    = 1 << PTR_W;
  localparam logic [2:0]        DEPTH_C  = 3'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [15:0]     inst_mem [SLOTS];
  logic [PC_W-1:0] pc_mem   [SLOTS];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [2:0]       count;

  logic [15:0]     id_inst;
  logic [PC_W-1:0] id_pc;
  logic            id_vld;

  logic accept, push, pop, bypass;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Fetch handshake: a word transfers on any edge where if_valid && if_ready; fetch may
  // hold or change its word freely while if_ready is low. Ready never depends on if_valid.
  assign if_ready = !rst && !PC_hazard &&
                    ((count < DEPTH_C) || (!data_hazard && count == 3'd0));
  assign accept   = if_valid && if_ready;

  always_comb begin
    push   = 1'b0;
    pop    = 1'b0;
    bypass = 1'b0;
    if (!PC_hazard) begin
      if (data_hazard) begin
        push = accept;
      end else if (count != 3'd0) begin
        pop  = 1'b1;
        push = accept;
      end else begin
        bypass = accept;
      end
    end
  end

  // Buffer storage carries data only; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= instruction;
      pc_mem[wr_ptr]   <= PC_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= 3'd0;
      id_vld  <= 1'b0;
      id_inst <= NOP_INST;
      id_pc   <= '0;
    end else if (PC_hazard) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= 3'd0;
      id_vld  <= 1'b0;
      id_inst <= NOP_INST;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (!data_hazard) begin
        if (pop) begin
          id_vld  <= 1'b1;
          id_inst <= inst_mem[rd_ptr];
          id_pc   <= pc_mem[rd_ptr];
        end else if (bypass) begin
          id_vld  <= 1'b1;
          id_inst <= instruction;
          id_pc   <= PC_in;
        end else begin
          // Bubble: PC_out keeps the last real PC.
          id_vld  <= 1'b0;
          id_inst <= NOP_INST;
        end
      end
    end
  end

  assign id_valid      = id_vld;
  assign cntrl_input   = id_inst[15:12];
  assign reg_rd        = id_inst[11:8];
  assign branch_cond   = id_inst[10:8];
  assign reg_rs        = id_inst[7:4];
  assign reg_rt        = id_inst[3:0];
  assign arith_imm     = id_inst[3:0];
  assign load_save_imm = id_inst[7:0];
  assign call_target   = id_inst[11:0];
  assign PC_out        = id_pc;
  assign buf_count     = count;

endmodule
